// File: rtl/relu_grad_gate_if.sv
// -----------------------------------------------------------------------------
// relu_grad_gate_if
// Streaming bus bundle for the ReLU gradient gate.
//   fwd_*  : forward pre-activation stream (valid/ready/data), into the gate
//   grad_* : upstream gradient stream (valid/ready/data), into the gate
//   gout_* : gated gradient stream (valid/ready/data), out of the gate
// Modports:
//   slave  : the gate itself
//   master : the environment driving forward data and gradients and
//            consuming the gated gradient
// -----------------------------------------------------------------------------
interface relu_grad_gate_if #(
    parameter int DATA_W = 8
);
    logic                     fwd_valid;
    logic signed [DATA_W-1:0] fwd_data;
    logic                     fwd_ready;

    logic                     grad_valid;
    logic signed [DATA_W-1:0] grad_data;
    logic                     grad_ready;

    logic                     gout_valid;
    logic signed [DATA_W-1:0] gout_data;
    logic                     gout_ready;

    modport slave (
        input  fwd_valid,
        input  fwd_data,
        output fwd_ready,
        input  grad_valid,
        input  grad_data,
        output grad_ready,
        output gout_valid,
        output gout_data,
        input  gout_ready
    );

    modport master (
        output fwd_valid,
        output fwd_data,
        input  fwd_ready,
        output grad_valid,
        output grad_data,
        input  grad_ready,
        input  gout_valid,
        input  gout_data,
        output gout_ready
    );
endinterface

// File: rtl/relu_grad_gate.sv
// -----------------------------------------------------------------------------
// relu_grad_gate
// Backward counterpart of the forward ReLU stage. In CAPTURE it snoops the
// forward pre-activation stream and stores one bit per element (1 = value was
// strictly positive). In BACKWARD it reads the bit for each incoming gradient
// and forwards the gradient unchanged where the bit is 1, zero elsewhere.
// Ports:
//   clk        rising-edge clock
//   rst_n      asynchronous active-low reset (also clears the mask)
//   abort      synchronous pulse: drop the current pass, return to CAPTURE
//   bus        relu_grad_gate_if.slave: fwd_*, grad_*, gout_* streams
//   fwd_done   one-cycle pulse after the last forward element is captured
//   bwd_done   one-cycle pulse after the last gradient is accepted
//   state_bwd  0 = CAPTURE, 1 = BACKWARD
// -----------------------------------------------------------------------------
module relu_grad_gate #(
    parameter int DATA_W   = 8,
    parameter int NUM_ELEM = 1024,
    parameter int CNT_W    = (NUM_ELEM > 1) ? $clog2(NUM_ELEM) : 1
) (
    input  logic            clk,
    input  logic            rst_n,
    input  logic            abort,
    relu_grad_gate_if.slave bus,
    output logic            fwd_done,
    output logic            bwd_done,
    output logic            state_bwd
);

    typedef enum logic {
        CAPTURE  = 1'b0,
        BACKWARD = 1'b1
    } state_e;

    state_e                   state_q, state_d;
    logic [CNT_W-1:0]         cnt_q, cnt_d;
    logic [NUM_ELEM-1:0]      mask_q;
    logic                     gout_valid_q, gout_valid_d;
    logic signed [DATA_W-1:0] gout_data_q, gout_data_d;
    logic                     fwd_done_q, bwd_done_q;

    logic fwd_ready_c;
    logic grad_ready_c;
    logic fwd_acc;
    logic grad_acc;
    logic cnt_last;
    logic mask_bit;

    // Strictly positive: sign bit clear and not zero.
    function automatic logic is_positive(input logic signed [DATA_W-1:0] v);
        return !v[DATA_W-1] && (v != '0);
    endfunction

    // Pass the gradient untouched (sign preserved, no widening) or zero it.
    function automatic logic signed [DATA_W-1:0] gate_grad(
        input logic                     keep,
        input logic signed [DATA_W-1:0] g
    );
        return keep ? g : '0;
    endfunction

    assign cnt_last = (cnt_q == CNT_W'(NUM_ELEM - 1));
    assign mask_bit = mask_q[cnt_q];

    // abort drops any handshake landing in the same cycle.
    assign fwd_acc  = bus.fwd_valid  && fwd_ready_c  && !abort;
    assign grad_acc = bus.grad_valid && grad_ready_c && !abort;

    // ---- FSM: state register ----
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= CAPTURE;
        end else begin
            state_q <= state_d;
        end
    end

    // ---- FSM: next-state logic ----
    always_comb begin
        state_d = state_q;
        if (abort) begin
            state_d = CAPTURE;
        end else begin
            case (state_q)
                CAPTURE:  if (fwd_acc && cnt_last)  state_d = BACKWARD;
                BACKWARD: if (grad_acc && cnt_last) state_d = CAPTURE;
                default:  state_d = CAPTURE;
            endcase
        end
    end

    // ---- FSM: outputs ----
    // A single output register: a new gradient can enter when the register
    // is empty or is being drained in this same cycle.
    always_comb begin
        fwd_ready_c  = (state_q == CAPTURE);
        grad_ready_c = (state_q == BACKWARD) && (!gout_valid_q || bus.gout_ready);
    end

    // ---- Datapath next-state ----
    always_comb begin
        cnt_d        = cnt_q;
        gout_valid_d = gout_valid_q;
        gout_data_d  = gout_data_q;

        if (abort) begin
            cnt_d = '0;
        end else if (fwd_acc || grad_acc) begin
            cnt_d = cnt_last ? '0 : cnt_q + CNT_W'(1);
        end

        // The gout register drains in either state; CAPTURE never loads it.
        if (abort) begin
            gout_valid_d = 1'b0;
        end else if (grad_acc) begin
            gout_valid_d = 1'b1;
            gout_data_d  = gate_grad(mask_bit, bus.grad_data);
        end else if (gout_valid_q && bus.gout_ready) begin
            gout_valid_d = 1'b0;
        end
    end

    // ---- Stage boundary: counter, mask, output register, done pulses ----
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt_q        <= '0;
            gout_valid_q <= 1'b0;
            gout_data_q  <= '0;
            fwd_done_q   <= 1'b0;
            bwd_done_q   <= 1'b0;
        end else begin
            cnt_q        <= cnt_d;
            gout_valid_q <= gout_valid_d;
            gout_data_q  <= gout_data_d;
            fwd_done_q   <= fwd_acc && cnt_last;
            bwd_done_q   <= grad_acc && cnt_last;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            mask_q <= '0;
        end else if (fwd_acc) begin
            mask_q[cnt_q] <= is_positive(bus.fwd_data);
        end
    end

    assign bus.fwd_ready  = fwd_ready_c;
    assign bus.grad_ready = grad_ready_c;
    assign bus.gout_valid = gout_valid_q;
    assign bus.gout_data  = gout_data_q;
    assign fwd_done       = fwd_done_q;
    assign bwd_done       = bwd_done_q;
    assign state_bwd      = (state_q == BACKWARD);

endmodule

// File: doc/relu_grad_gate.md
Name: relu_grad_gate

Overview:
- Backward-direction counterpart of the forward ReLU activation stage in the Classification-CNN datapath.
- During the forward pass it snoops the pre-activation stream and records one sign-mask bit per element.
- During the backward pass it reads that mask back and gates the incoming gradient stream: the gradient passes where the forward input was > 0 and is zeroed elsewhere.
- Sits between the loss/upstream-gradient producer and the preceding conv layer's gradient input.

Parameters:
- DATA_W, 8, width of forward data and gradient words; both are signed two's complement.
- NUM_ELEM, 1024, number of elements per tensor (H*W*C flattened); mask depth.
- CNT_W, $clog2(NUM_ELEM), element counter width.

Ports:
- clk  in  1  rising-edge clock.
- rst_n  in  1  asynchronous active-low reset.
- abort  in  1  synchronous pulse; discards the current pass and returns to CAPTURE.
- fwd_valid  in  1  forward pre-activation element valid.
- fwd_data  in  DATA_W  signed pre-activation element.
- fwd_ready  out  1  block accepts a forward element.
- grad_valid  in  1  upstream gradient valid.
- grad_data  in  DATA_W  signed upstream gradient.
- grad_ready  out  1  block accepts a gradient.
- gout_valid  out  1  gated gradient valid.
- gout_data  out  DATA_W  gated gradient.
- gout_ready  in  1  downstream accepts the gated gradient.
- fwd_done  out  1  one-cycle pulse when the last forward element is captured.
- bwd_done  out  1  one-cycle pulse when the last gradient is accepted.
- state_bwd  out  1  0 = CAPTURE, 1 = BACKWARD.

Behaviour:
- Reset (rst_n low, asynchronous):
  - State is CAPTURE and cnt = 0.
  - Outputs: gout_valid = 0, gout_data = 0, fwd_done = 0, bwd_done = 0, state_bwd = 0.
  - Mask contents are cleared to 0.
- CAPTURE state:
  - fwd_ready = 1 and grad_ready = 0.
  - On fwd_valid & fwd_ready: mask[cnt] <= (fwd_data signed > 0). Zero and negative values store 0.
  - cnt increments on each accepted element.
  - When cnt == NUM_ELEM-1 and an element is accepted: cnt <= 0, state <= BACKWARD, and fwd_done pulses high on the next cycle.
- BACKWARD state:
  - fwd_ready = 0.
  - grad_ready = !gout_valid | gout_ready (single output register; full throughput when downstream is always ready).
  - On grad_valid & grad_ready:
    - gout_data <= mask[cnt] ? grad_data : 0.
    - gout_valid <= 1.
    - cnt increments.
  - Latency is 1 cycle from accept to gout_valid.
  - If gout_valid & gout_ready and no new accept: gout_valid <= 0. gout_data holds its value.
  - gout_valid/gout_data stay stable while gout_valid & !gout_ready.
  - When the last gradient (cnt == NUM_ELEM-1) is accepted: cnt <= 0, state <= CAPTURE, and bwd_done pulses the next cycle.
  - The final gout beat may still be pending after the return to CAPTURE. It drains normally; the CAPTURE logic does not touch gout.
- Counter wrap: cnt never exceeds NUM_ELEM-1. NUM_ELEM need not be a power of two.
- abort (sampled at the clock edge):
  - cnt <= 0, state <= CAPTURE, gout_valid <= 0.
  - No done pulse is generated.
  - Any handshake in the same cycle is dropped: mask is not written and no output is produced.
  - Mask contents are retained but are considered stale.
- Simultaneous fwd_valid and grad_valid: only the stream matching the current state is accepted; the other stream sees ready = 0.
- Mask storage is an NUM_ELEM x 1 register array with a combinational read at cnt. There is no pointer beyond cnt.
- Arithmetic: no widening. gout_data is exactly grad_data or 0. Sign is preserved (e.g. -5 passes as -5 when the mask bit is 1).

Test Plan:
- NUM_ELEM=4, forward {3, -2, 0, 127}, then gradients {10, 11, 12, -7} with gout_ready=1 → gout sequence {10, 0, 0, -7}; fwd_done pulses once after element 4; bwd_done pulses once; state_bwd returns to 0.
- Backpressure: NUM_ELEM=4, forward {1,1,1,1}, gout_ready low for 3 cycles after the first accept → grad_ready=0 while stalled, gout_data=first gradient held stable, no beat lost or duplicated.
- Wrong-phase traffic: grad_valid=1 during CAPTURE and fwd_valid=1 during BACKWARD → respective ready=0 and mask/outputs unchanged.
- abort asserted after 2 of 4 gradients, in the same cycle as a grad handshake → gout_valid=0 next cycle, cnt=0, state CAPTURE, no bwd_done; a new forward pass {-1,-1,-1,-1} then gradients {5,5,5,5} → all outputs 0.
- Async reset mid-BACKWARD with gout_valid=1 → gout_valid=0 and state_bwd=0 immediately, without waiting for a clock edge; mask cleared so gradients after a reset-then-capture of zeros yield 0.
- Back-to-back passes with NUM_ELEM=1024 and random data, checked against a reference model, with continuous valid and ready → one gout per cycle and output exactly 1 cycle behind input.
